cnt_tick_gen: RTL and testbench

//  Count-enable generator: drives the T input of the first stage of the 3-bit synchronous
//  T-flip-flop counter. Prescales clk by a programmable divisor and gates ticks with a

---
 rtl/cnt_tick_pkg.sv | 16 +
 rtl/btn_edge_det.sv | 28 ++
 rtl/cnt_tick_gen.sv | 145 ++++++++++++++
 tb/tb_cnt_tick_gen.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cnt_tick_pkg.sv
// Shared types and defaults for the count-enable tick generator.
//   tick_state_t : control FSM encoding (IDLE / RUN / STEP)
//   DEF_DIV_W    : default width of divisor and prescaler counter
//   DEF_CNT_W    : default width of the emitted-tick counter
package cnt_tick_pkg;

  localparam int unsigned DEF_DIV_W = 8;
  localparam int unsigned DEF_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2
  } tick_state_t;

endpackage

// File: rtl/btn_edge_det.sv
// Rising-edge detector for a raw button level.
//   clk  in  : clock, rising edge
//   nrst in  : asynchronous reset, active-low
//   lvl  in  : raw button level
//   edg  out : combinational one-cycle pulse, lvl high while previous sample was low
// History resets to 1 so a button already held through reset does not
// produce an edge on release of reset. Output is named edg because "edge"
// is a reserved word.
module btn_edge_det (
  input  logic clk,
  input  logic nrst,
  input  logic lvl,
  output logic edg
);

  logic r_prev;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_prev <= 1'b1;
    end else begin
      r_prev <= lvl;
    end
  end

  assign edg = lvl & ~r_prev;

endmodule

// File: rtl/cnt_tick_gen.sv
// Count-enable generator feeding the T input of stage 0 of the 3-bit
// synchronous T-flip-flop counter. Prescales clk by (div+1) and gates the
// resulting ticks with a start / stop / single-step control FSM driven by
// raw button levels.
//   clk      in  : single clock, rising edge
//   nrst     in  : asynchronous reset, active-low
//   div      in  : tick period minus 1 (0 = tick every cycle), sampled live
//   start    in  : button level, rising edge starts free-run
//   stop     in  : button level, rising edge stops free-run
//   step     in  : button level, rising edge emits one tick from IDLE
//   en_out   out : registered one-cycle tick to the counter T input
//   running  out : high while the FSM is in RUN
//   tick_cnt out : number of en_out pulses emitted, wraps
module cnt_tick_gen
  import cnt_tick_pkg::*;
#(
  parameter int unsigned DIV_W = DEF_DIV_W,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic [DIV_W-1:0] div,
  input  logic             start,
  input  logic             stop,
  input  logic             step,
  output logic             en_out,
  output logic             running,
  output logic [CNT_W-1:0] tick_cnt
);

  tick_state_t      r_state;
  tick_state_t      w_state_nxt;
  logic [DIV_W-1:0] r_pre_cnt;
  logic [DIV_W-1:0] w_pre_nxt;
  logic             r_en_out;
  logic [CNT_W-1:0] r_tick_cnt;
  logic             w_tick;
  logic             w_start_edge;
  logic             w_stop_edge;
  logic             w_step_edge;

  btn_edge_det u_start_det (
    .clk  (clk),
    .nrst (nrst),
    .lvl  (start),
    .edg  (w_start_edge)
  );

  btn_edge_det u_stop_det (
    .clk  (clk),
    .nrst (nrst),
    .lvl  (stop),
    .edg  (w_stop_edge)
  );

  btn_edge_det u_step_det (
    .clk  (clk),
    .nrst (nrst),
    .lvl  (step),
    .edg  (w_step_edge)
  );

  // State register
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; stop outranks start, start outranks step
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_stop_edge) begin
          w_state_nxt = IDLE;
        end else if (w_start_edge) begin
          w_state_nxt = RUN;
        end else if (w_step_edge) begin
          w_state_nxt = STEP;
        end
      end
      RUN: begin
        if (w_stop_edge) begin
          w_state_nxt = IDLE;
        end
      end
      STEP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Output / prescaler logic. The >= compare means lowering div below the
  // current count fires on the next RUN cycle instead of waiting for a wrap.
  always_comb begin
    w_tick    = 1'b0;
    w_pre_nxt = r_pre_cnt;
    unique case (r_state)
      IDLE: begin
        if (!w_stop_edge && w_start_edge) begin
          w_pre_nxt = '0;
        end
      end
      RUN: begin
        if (w_stop_edge) begin
          w_pre_nxt = '0;
        end else if (r_pre_cnt >= div) begin
          w_tick    = 1'b1;
          w_pre_nxt = '0;
        end else begin
          w_pre_nxt = r_pre_cnt + DIV_W'(1);
        end
      end
      STEP: begin
        w_tick = 1'b1;
      end
      default: begin
        w_tick    = 1'b0;
        w_pre_nxt = '0;
      end
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_pre_cnt  <= '0;
      r_en_out   <= 1'b0;
      r_tick_cnt <= '0;
    end else begin
      r_pre_cnt <= w_pre_nxt;
      r_en_out  <= w_tick;
      if (w_tick) begin
        r_tick_cnt <= r_tick_cnt + CNT_W'(1);
      end
    end
  end

  assign en_out   = r_en_out;
  assign running  = (r_state == RUN);
  assign tick_cnt = r_tick_cnt;

endmodule

// File: tb/tb_cnt_tick_gen.sv
// Scoreboard bench for cnt_tick_gen. Cycle k is the interval following the
// k-th rising clock edge; inputs are driven 1 ns after the edge that opens
// their cycle and outputs are sampled on the falling edge of that cycle.
// The stimulus process queues every expected en_out pulse (cycle and
// tick_cnt); the monitor pops one entry per observed pulse.
module tb_cnt_tick_gen;

  logic        clk = 1'b0;
  logic        nrst;
  logic [7:0]  div;
  logic        start;
  logic        stop;
  logic        step;
  logic        en_out;
  logic        running;
  logic [15:0] tick_cnt;
  logic        w_en_out;
  logic        w_running;
  logic [3:0]  w_tick_cnt;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int exp_n = 0;

  typedef struct {
    int cyc;
    int cnt;
  } tick_t;

  tick_t q[$];

  cnt_tick_gen #(.DIV_W(8), .CNT_W(16)) u_dut (
    .clk      (clk),
    .nrst     (nrst),
    .div      (div),
    .start    (start),
    .stop     (stop),
    .step     (step),
    .en_out   (en_out),
    .running  (running),
    .tick_cnt (tick_cnt)
  );

  // Narrow tick counter, same stimulus, to exercise wrap-around
  cnt_tick_gen #(.DIV_W(8), .CNT_W(4)) u_dut_w (
    .clk      (clk),
    .nrst     (nrst),
    .div      (div),
    .start    (start),
    .stop     (stop),
    .step     (step),
    .en_out   (w_en_out),
    .running  (w_running),
    .tick_cnt (w_tick_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic push(input int c);
    tick_t t;
    exp_n++;
    t.cyc = c;
    t.cnt = exp_n;
    q.push_back(t);
  endtask

  task automatic at(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (nrst === 1'b1) begin
      while (q.size() > 0 && q[0].cyc < cyc) begin
        total++;
        bad++;
        $display("FAIL tick_missed: expected en_out @cyc %0d, absent through cyc %0d", q[0].cyc, cyc);
        void'(q.pop_front());
      end
      if (en_out !== 1'b0) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL tick_unexpected @cyc %0d: got en_out=%b expected 0", cyc, en_out);
        end else begin
          tick_t e;
          e = q.pop_front();
          chk("tick_cycle", cyc, e.cyc);
          chk("tick_cnt", tick_cnt, e.cnt % 65536);
          chk("wrap_tick_cnt", w_tick_cnt, e.cnt % 16);
          chk("wrap_en_out", w_en_out, 1);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish by time limit");
    $fatal(1);
  end

  initial begin
    nrst  = 1'b0;
    start = 1'b1;
    stop  = 1'b0;
    step  = 1'b0;
    div   = 8'd3;

    // Reset values, start held through reset release
    at(2);
    chk("rst_en_out", en_out, 0);
    chk("rst_running", running, 0);
    chk("rst_tick_cnt", tick_cnt, 0);
    chk("rst_wrap_cnt", w_tick_cnt, 0);
    at(3);
    nrst = 1'b1;
    at(6);
    chk("held_start_running", running, 0);
    at(7);
    start = 1'b0;
    at(8);
    chk("held_start_idle", running, 0);

    // div=3 free-run, stop timed on a would-be terminal count
    div = 8'd3;
    at(10);
    start = 1'b1;
    push(15); push(19); push(23);
    chk("t1_pre_running", running, 0);
    at(11);
    start = 1'b0;
    chk("t1_running", running, 1);
    at(26);
    stop = 1'b1;
    at(27);
    stop = 1'b0;
    chk("t1_stopped", running, 0);

    // div=0: tick every cycle from n+2, stop at m -> none from m+1
    div = 8'd0;
    at(40);
    start = 1'b1;
    for (int c = 42; c <= 50; c++) push(c);
    at(41);
    start = 1'b0;
    at(50);
    stop = 1'b1;
    at(51);
    stop = 1'b0;
    chk("t2_stopped", running, 0);
    chk("t2_no_tick_after_stop", en_out, 0);

    // single step, then step held for 50 cycles
    div = 8'd5;
    at(60);
    step = 1'b1;
    push(62);
    at(61);
    step = 1'b0;
    chk("t3_step_not_run", running, 0);
    at(63);
    chk("t3_idle_after", running, 0);
    at(70);
    step = 1'b1;
    push(72);
    at(120);
    step = 1'b0;
    at(121);
    chk("t3_tick_cnt", tick_cnt, 14);

    // simultaneous edges in IDLE: stop wins
    at(130);
    start = 1'b1;
    stop  = 1'b1;
    at(131);
    start = 1'b0;
    stop  = 1'b0;
    chk("t4_start_stop_idle", running, 0);
    at(140);
    stop = 1'b1;
    step = 1'b1;
    at(141);
    stop = 1'b0;
    step = 1'b0;
    at(145);
    chk("t4_no_tick", tick_cnt, 14);
    chk("t4_idle", running, 0);

    // div lowered mid-run below pre_cnt=7 -> tick next cycle, then period 3
    div = 8'd10;
    at(150);
    start = 1'b1;
    push(159); push(162); push(165); push(168);
    at(151);
    start = 1'b0;
    at(158);
    div = 8'd2;
    at(169);
    stop = 1'b1;
    at(170);
    stop = 1'b0;
    chk("t5_stopped", running, 0);
    chk("t5_wrap_cnt", w_tick_cnt, 2);

    // async reset while RUN, with a tick high at that moment
    div = 8'd1;
    at(180);
    start = 1'b1;
    push(183); push(185);
    at(181);
    start = 1'b0;
    at(187);
    #1;
    nrst = 1'b0;
    #1;
    chk("t6_rst_en_out", en_out, 0);
    chk("t6_rst_running", running, 0);
    chk("t6_rst_tick_cnt", tick_cnt, 0);
    chk("t6_rst_wrap_cnt", w_tick_cnt, 0);
    exp_n = 0;
    at(190);
    nrst = 1'b1;
    at(195);
    step = 1'b1;
    push(197);
    at(196);
    step = 1'b0;
    at(205);
    chk("final_queue_empty", q.size(), 0);
    chk("final_running", running, 0);
    chk("final_tick_cnt", tick_cnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
